pipe_stage_buffer: RTL and testbench

- Parametrised pipeline-stage register for the processor datapath. Replaces the fixed-width, always-loading inter-stage buffers between IF/ID, ID/EX, EX/MEM and MEM/WB.
- Carries one data bus and one control bundle per stage. Adds a valid/ready handshake, a 2-entry skid so stalls never drop an instruction, and a synchronous flush that inserts a bubble.
- One instance per stage boundary; widths are set per instance.

---
 rtl/pipe_stage_buffer.sv | 109 ++++++++++
 tb/tb_pipe_stage_buffer.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_buffer.sv
// Pipeline stage register with valid/ready handshake, a 2-entry skid and a synchronous flush.
// The main register drives the outputs; the skid catches the one instruction accepted during a stall.
module pipe_stage_buffer #(
    parameter int                DATA_W      = 64,
    parameter int                CTRL_W      = 8,
    parameter logic [CTRL_W-1:0] BUBBLE_CTRL = '0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    input  logic              out_ready,
    input  logic              flush,
    output logic [1:0]        occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] main_data, skid_data;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
    logic              accept, emit;
    logic              main_from_in, main_from_skid, skid_from_in;

    // in_ready looks at state only, so no combinational path from out_ready to in_ready.
    assign in_ready  = (state != TWO);
    assign out_valid = (state != EMPTY);
    assign accept    = in_valid & in_ready;
    assign emit      = out_valid & out_ready;

    assign out_data  = main_data;
    assign out_ctrl  = out_valid ? main_ctrl : BUBBLE_CTRL;
    assign occupancy = (state == TWO) ? 2'd2 : (state == ONE) ? 2'd1 : 2'd0;

    always_comb begin
        state_nxt      = state;
        main_from_in   = 1'b0;
        main_from_skid = 1'b0;
        skid_from_in   = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    main_from_in = 1'b1;
                    state_nxt    = ONE;
                end
            end
            ONE: begin
                if (emit && accept) begin
                    main_from_in = 1'b1;
                end else if (emit) begin
                    state_nxt = EMPTY;
                end else if (accept) begin
                    skid_from_in = 1'b1;
                    state_nxt    = TWO;
                end
            end
            TWO: begin
                if (emit) begin
                    main_from_skid = 1'b1;
                    state_nxt      = ONE;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)        state <= EMPTY;
        else if (flush) state <= EMPTY;
        else            state <= state_nxt;
    end

    // Flush drops any same-cycle accept; a same-cycle emit has already been taken downstream.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            main_data <= '0;
            main_ctrl <= BUBBLE_CTRL;
            skid_data <= '0;
            skid_ctrl <= BUBBLE_CTRL;
        end else if (flush) begin
            main_data <= '0;
            main_ctrl <= BUBBLE_CTRL;
            skid_data <= '0;
            skid_ctrl <= BUBBLE_CTRL;
        end else begin
            if (main_from_in) begin
                main_data <= in_data;
                main_ctrl <= in_ctrl;
            end else if (main_from_skid) begin
                main_data <= skid_data;
                main_ctrl <= skid_ctrl;
            end
            if (skid_from_in) begin
                skid_data <= in_data;
                skid_ctrl <= in_ctrl;
            end
        end
    end

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Self-checking bench for pipe_stage_buffer: directed scenarios plus random traffic
// compared against a FIFO queue model of at most two entries.
module tb_pipe_stage_buffer;

    localparam int                DW     = 32;
    localparam int                CW     = 8;
    localparam logic [CW-1:0]     BUBBLE = 8'h00;

    logic          CLK, RST;
    logic          in_valid, in_ready, out_valid, out_ready, flush;
    logic [DW-1:0] in_data, out_data;
    logic [CW-1:0] in_ctrl, out_ctrl;
    logic [1:0]    occupancy;

    pipe_stage_buffer #(.DATA_W(DW), .CTRL_W(CW), .BUBBLE_CTRL(BUBBLE)) dut (
        .CLK(CLK), .RST(RST),
        .in_valid(in_valid), .in_data(in_data), .in_ctrl(in_ctrl), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ctrl(out_ctrl), .out_ready(out_ready),
        .flush(flush), .occupancy(occupancy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } ent_t;

    ent_t          q[$];
    logic [DW-1:0] last_shown;
    int            n_checks = 0;
    int            n_errors = 0;
    int            n_emitted = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        chk("occupancy", 64'(occupancy), 64'(q.size()));
        chk("in_ready",  64'(in_ready),  64'(q.size() < 2));
        chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
        if (q.size() != 0) begin
            chk("out_data", 64'(out_data), 64'(q[0].d));
            chk("out_ctrl", 64'(out_ctrl), 64'(q[0].c));
            last_shown = q[0].d;
        end else begin
            chk("bubble_ctrl", 64'(out_ctrl), 64'(BUBBLE));
            chk("idle_data",   64'(out_data), 64'(last_shown));
        end
    endtask

    // Drive one cycle's inputs, check outputs, then advance the model at the edge.
    task automatic step(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                        input logic r, input logic f);
        bit acc, emt;
        @(negedge CLK);
        in_valid = v; in_data = d; in_ctrl = c; out_ready = r; flush = f;
        #1;
        check_outputs();
        acc = v && (q.size() < 2);
        emt = r && (q.size() != 0);
        @(posedge CLK);
        if (emt) n_emitted++;
        if (f) begin
            q.delete();
            last_shown = '0;
        end else begin
            if (emt) void'(q.pop_front());
            if (acc) q.push_back('{d: d, c: c});
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        q.delete();
        last_shown = '0;
    endtask

    initial begin
        RST = 1'b1; in_valid = 1'b0; in_data = '0; in_ctrl = '0; out_ready = 1'b0; flush = 1'b0;
        last_shown = '0;
        repeat (2) @(posedge CLK);
        do_reset();

        // reset state, then pass-through 1,2,3
        step(1'b1, 32'h1, 8'h11, 1'b1, 1'b0);
        step(1'b1, 32'h2, 8'h12, 1'b1, 1'b0);
        step(1'b1, 32'h3, 8'h13, 1'b1, 1'b0);
        step(1'b0, 32'h0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 32'h0, 8'h00, 1'b1, 1'b0);

        // stall/skid: hold 0xA, accept 0xB while stalled, then drain
        step(1'b1, 32'hA, 8'h0A, 1'b0, 1'b0);
        step(1'b1, 32'hB, 8'h0B, 1'b0, 1'b0);
        step(1'b1, 32'hF0, 8'hF0, 1'b0, 1'b0);   // refused: full
        step(1'b0, 32'h0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 32'h0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 32'h0, 8'h00, 1'b1, 1'b0);

        // bubble control: valid every other cycle with ctrl 0xFF
        for (int i = 0; i < 6; i++)
            step(i[0] == 1'b0, 32'h100 + 32'(i), 8'hFF, 1'b1, 1'b0);
        step(1'b0, 32'h0, 8'h00, 1'b1, 1'b0);

        // flush at full: 0xC,0xD held, flush with 0xE offered
        step(1'b1, 32'hC, 8'h0C, 1'b0, 1'b0);
        step(1'b1, 32'hD, 8'h0D, 1'b0, 1'b0);
        step(1'b1, 32'hE, 8'h0E, 1'b0, 1'b1);
        step(1'b0, 32'h0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 32'h0, 8'h00, 1'b1, 1'b0);

        // flush with simultaneous emit and accept from ONE
        step(1'b1, 32'h21, 8'h21, 1'b1, 1'b0);
        step(1'b1, 32'h22, 8'h22, 1'b1, 1'b1);
        step(1'b0, 32'h0, 8'h00, 1'b1, 1'b0);

        // async reset mid-stall, observed before the next edge
        step(1'b1, 32'h31, 8'h31, 1'b0, 1'b0);
        step(1'b1, 32'h32, 8'h32, 1'b0, 1'b0);
        @(negedge CLK);
        in_valid = 1'b0; out_ready = 1'b0;
        #1;
        chk("pre_rst_occ", 64'(occupancy), 64'd2);
        RST = 1'b1;
        #1;
        chk("async_out_valid", 64'(out_valid), 64'd0);
        chk("async_in_ready",  64'(in_ready),  64'd1);
        chk("async_occ",       64'(occupancy), 64'd0);
        chk("async_data",      64'(out_data),  64'd0);
        #1;
        RST = 1'b0;
        q.delete();
        last_shown = '0;
        step(1'b1, 32'h41, 8'h41, 1'b1, 1'b0);
        step(1'b0, 32'h0, 8'h00, 1'b1, 1'b0);

        // random traffic
        for (int i = 0; i < 10000; i++) begin
            int vbias = (i / 1000) % 3;
            step($urandom_range(0, 9) < 4 + 2 * vbias, $urandom, 8'($urandom),
                 $urandom_range(0, 9) < 7 - 2 * vbias, $urandom_range(0, 99) < 3);
        end
        step(1'b0, 32'h0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 32'h0, 8'h00, 1'b1, 1'b0);
        check_outputs();
        if (n_emitted < 1000) begin
            n_errors++;
            $display("FAIL emitted_count: got %0d expected at least 1000", n_emitted);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
